// File: rtl/univ_shift_reg_pkg.sv
// Shared mode encodings and sizing helper for the universal shift register.
package univ_shift_reg_pkg;

  localparam logic [2:0] MODE_HOLD = 3'b000;
  localparam logic [2:0] MODE_SHR  = 3'b001;
  localparam logic [2:0] MODE_SHL  = 3'b010;
  localparam logic [2:0] MODE_LOAD = 3'b011;
  localparam logic [2:0] MODE_ROR  = 3'b100;
  localparam logic [2:0] MODE_ROL  = 3'b101;
  localparam logic [2:0] MODE_JOHN = 3'b110;
  localparam logic [2:0] MODE_ASR  = 3'b111;

  // Counter must represent 0..width inclusive.
  function automatic int cnt_w(input int width);
    return $clog2(width + 1);
  endfunction

endpackage

// File: rtl/univ_shift_reg_next_mux.sv
// Combinational next-state selector: picks the post-edge register value for each mode.
module usr_next_mux
  import univ_shift_reg_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic [WIDTH-1:0] q,
  input  logic [WIDTH-1:0] d,
  input  logic [2:0]       mode,
  input  logic             sin_msb,
  input  logic             sin_lsb,
  output logic [WIDTH-1:0] q_next,
  output logic             is_shift
);

  always_comb begin
    q_next   = q;
    is_shift = 1'b1;
    case (mode)
      MODE_HOLD: is_shift = 1'b0;
      MODE_SHR:  q_next   = {sin_msb, q[WIDTH-1:1]};
      MODE_SHL:  q_next   = {q[WIDTH-2:0], sin_lsb};
      MODE_LOAD: begin
        q_next   = d;
        is_shift = 1'b0;
      end
      MODE_ROR:  q_next   = {q[0], q[WIDTH-1:1]};
      MODE_ROL:  q_next   = {q[WIDTH-2:0], q[WIDTH-1]};
      MODE_JOHN: q_next   = {q[WIDTH-2:0], ~q[WIDTH-1]};
      MODE_ASR:  q_next   = {q[WIDTH-1], q[WIDTH-1:1]};
      default:   is_shift = 1'b0;
    endcase
  end

endmodule

// File: rtl/univ_shift_reg.sv
// Universal WIDTH-bit register: shift/rotate/load/Johnson modes with a saturating
// shift counter that flags a completed word.
module univ_shift_reg
  import univ_shift_reg_pkg::*;
#(
  parameter int               WIDTH   = 8,
  parameter logic [WIDTH-1:0] RST_VAL = {WIDTH{1'b0}},
  parameter logic [WIDTH-1:0] SET_VAL = {WIDTH{1'b1}}
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      set,
  input  logic                      en,
  input  logic [2:0]                mode,
  input  logic                      sin_msb,
  input  logic                      sin_lsb,
  input  logic [WIDTH-1:0]          d,
  output logic [WIDTH-1:0]          q,
  output logic                      sout_msb,
  output logic                      sout_lsb,
  output logic [cnt_w(WIDTH)-1:0]   shcnt,
  output logic                      word_done
);

  localparam int            CW      = cnt_w(WIDTH);
  localparam logic [CW-1:0] CNT_MAX = CW'(WIDTH);

  logic [WIDTH-1:0] q_next;
  logic             is_shift;
  logic [CW-1:0]    cnt_next;

  usr_next_mux #(.WIDTH(WIDTH)) u_next_mux (
    .q        (q),
    .d        (d),
    .mode     (mode),
    .sin_msb  (sin_msb),
    .sin_lsb  (sin_lsb),
    .q_next   (q_next),
    .is_shift (is_shift)
  );

  // Counter saturates at WIDTH so word_done stays up until a load/set/reset.
  always_comb begin
    cnt_next = shcnt;
    if (mode == MODE_LOAD)
      cnt_next = '0;
    else if (is_shift && (shcnt < CNT_MAX))
      cnt_next = shcnt + CW'(1);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      q         <= RST_VAL;
      shcnt     <= '0;
      word_done <= 1'b0;
    end else if (set) begin
      q         <= SET_VAL;
      shcnt     <= '0;
      word_done <= 1'b0;
    end else if (en) begin
      q         <= q_next;
      shcnt     <= cnt_next;
      word_done <= (cnt_next == CNT_MAX);
    end
  end

  assign sout_msb = q[WIDTH-1];
  assign sout_lsb = q[0];

endmodule

// File: tb/tb_univ_shift_reg.sv
// Directed plus randomized bench for univ_shift_reg (WIDTH=8) against an arithmetic reference model.
module tb_univ_shift_reg;
  import univ_shift_reg_pkg::*;

  logic       clk;
  logic       rst;
  logic       set;
  logic       en;
  logic [2:0] mode;
  logic       sin_msb;
  logic       sin_lsb;
  logic [7:0] d;
  logic [7:0] q;
  logic       sout_msb;
  logic       sout_lsb;
  logic [3:0] shcnt;
  logic       word_done;

  int checks = 0;
  int errors = 0;

  int m_q;
  int m_cnt;
  int m_wd;

  univ_shift_reg #(.WIDTH(8), .RST_VAL(8'h00), .SET_VAL(8'hFF)) dut (
    .clk       (clk),
    .rst       (rst),
    .set       (set),
    .en        (en),
    .mode      (mode),
    .sin_msb   (sin_msb),
    .sin_lsb   (sin_lsb),
    .d         (d),
    .q         (q),
    .sout_msb  (sout_msb),
    .sout_lsb  (sout_lsb),
    .shcnt     (shcnt),
    .word_done (word_done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Reference: each mode expressed as plain integer arithmetic on an 8-bit word.
  task automatic model(input logic s, input logic e, input logic [2:0] m,
                       input logic smsb, input logic slsb, input logic [7:0] dd);
    int nq;
    bit shifting;
    if (s) begin
      m_q = 255; m_cnt = 0; m_wd = 0;
      return;
    end
    if (!e) return;
    nq = m_q;
    shifting = 1;
    case (m)
      3'd0: shifting = 0;
      3'd1: nq = (m_q / 2) + (smsb ? 128 : 0);
      3'd2: nq = ((m_q * 2) % 256) + (slsb ? 1 : 0);
      3'd3: begin nq = dd; shifting = 0; end
      3'd4: nq = (m_q / 2) + ((m_q % 2) * 128);
      3'd5: nq = ((m_q * 2) % 256) + (m_q / 128);
      3'd6: nq = ((m_q * 2) % 256) + (1 - m_q / 128);
      default: nq = (m_q / 2) + (m_q >= 128 ? 128 : 0);
    endcase
    if (m == 3'd3) m_cnt = 0;
    else if (shifting && m_cnt < 8) m_cnt = m_cnt + 1;
    m_wd = (m_cnt == 8) ? 1 : 0;
    m_q = nq;
  endtask

  task automatic check_all(input string tag);
    chk({tag, ".q"}, {24'h0, q}, m_q);
    chk({tag, ".shcnt"}, {28'h0, shcnt}, m_cnt);
    chk({tag, ".word_done"}, {31'h0, word_done}, m_wd);
    chk({tag, ".sout_msb"}, {31'h0, sout_msb}, (m_q / 128) % 2);
    chk({tag, ".sout_lsb"}, {31'h0, sout_lsb}, m_q % 2);
  endtask

  task automatic step(input string tag, input logic s, input logic e, input logic [2:0] m,
                      input logic smsb, input logic slsb, input logic [7:0] dd);
    set = s; en = e; mode = m; sin_msb = smsb; sin_lsb = slsb; d = dd;
    model(s, e, m, smsb, slsb, dd);
    @(posedge clk);
    #1;
    check_all(tag);
  endtask

  task automatic model_reset();
    m_q = 0; m_cnt = 0; m_wd = 0;
  endtask

  initial begin
    logic [7:0] pat;
    logic [7:0] jseq [16];
    jseq = '{8'h01, 8'h03, 8'h07, 8'h0F, 8'h1F, 8'h3F, 8'h7F, 8'hFF,
             8'hFE, 8'hFC, 8'hF8, 8'hF0, 8'hE0, 8'hC0, 8'h80, 8'h00};

    rst = 1'b0; set = 1'b0; en = 1'b0; mode = MODE_HOLD;
    sin_msb = 1'b0; sin_lsb = 1'b0; d = 8'h00;
    model_reset();
    #12;
    check_all("reset");
    @(negedge clk) rst = 1'b1;
    @(posedge clk); #1;

    // Set, and set with en=0
    step("set", 1, 1, MODE_HOLD, 0, 0, 8'h00);
    chk("set_ff", {24'h0, q}, 32'hFF);
    step("load12", 0, 1, MODE_LOAD, 0, 0, 8'h12);
    step("set_en0", 1, 0, MODE_SHL, 0, 0, 8'h00);
    chk("set_en0_ff", {24'h0, q}, 32'hFF);

    // Asynchronous reset with no clock edge
    step("load5a", 0, 1, MODE_LOAD, 0, 0, 8'h5A);
    #2 rst = 1'b0;
    #1;
    model_reset();
    check_all("async_rst");
    @(negedge clk) rst = 1'b1;

    // Serializer
    step("ser_load", 0, 1, MODE_LOAD, 0, 0, 8'hA5);
    pat = 8'hA5;
    for (int i = 0; i < 8; i++) begin
      chk("ser_sout_msb", {31'h0, sout_msb}, {31'h0, pat[7-i]});
      chk("ser_wd_early", {31'h0, word_done}, 32'h0);
      step("ser_shl", 0, 1, MODE_SHL, 0, 0, 8'h00);
    end
    chk("ser_q", {24'h0, q}, 32'h00);
    chk("ser_cnt8", {28'h0, shcnt}, 32'd8);
    chk("ser_wd", {31'h0, word_done}, 32'h1);
    step("ser_9th", 0, 1, MODE_SHL, 0, 0, 8'h00);
    chk("ser_sat", {28'h0, shcnt}, 32'd8);
    step("load_after_wd", 0, 1, MODE_LOAD, 0, 0, 8'h33);
    chk("load_clr_wd", {31'h0, word_done}, 32'h0);

    // Rotate and arithmetic shift
    step("ld81", 0, 1, MODE_LOAD, 0, 0, 8'h81);
    step("rol", 0, 1, MODE_ROL, 0, 0, 8'h00);
    chk("rol_03", {24'h0, q}, 32'h03);
    step("ror", 0, 1, MODE_ROR, 0, 0, 8'h00);
    chk("ror_81", {24'h0, q}, 32'h81);
    step("ld90", 0, 1, MODE_LOAD, 0, 0, 8'h90);
    step("asr1", 0, 1, MODE_ASR, 0, 0, 8'h00);
    chk("asr_c8", {24'h0, q}, 32'hC8);
    step("asr2", 0, 1, MODE_ASR, 0, 0, 8'h00);
    chk("asr_e4", {24'h0, q}, 32'hE4);
    step("ld00", 0, 1, MODE_LOAD, 0, 0, 8'h00);
    step("shr", 0, 1, MODE_SHR, 1, 0, 8'h00);
    chk("shr_80", {24'h0, q}, 32'h80);

    // Johnson from reset
    @(negedge clk) rst = 1'b0;
    model_reset();
    @(negedge clk) rst = 1'b1;
    for (int i = 0; i < 16; i++) begin
      step("john", 0, 1, MODE_JOHN, 0, 0, 8'h00);
      chk("john_tbl", {24'h0, q}, {24'h0, jseq[i]});
    end

    // Enable and priority
    step("ld_en", 0, 1, MODE_LOAD, 0, 0, 8'h6C);
    step("shl_en", 0, 1, MODE_SHL, 0, 1, 8'h00);
    for (int i = 0; i < 3; i++) step("en0_hold", 0, 0, MODE_SHL, 0, 1, 8'h00);
    chk("en0_q", {24'h0, q}, 32'hD9);
    chk("en0_cnt", {28'h0, shcnt}, 32'd1);
    step("set_vs_load", 1, 1, MODE_LOAD, 0, 0, 8'h3C);
    chk("set_wins", {24'h0, q}, 32'hFF);

    // Reset during shifting
    step("rs_shl1", 0, 1, MODE_SHL, 0, 1, 8'h00);
    step("rs_shl2", 0, 1, MODE_SHL, 0, 1, 8'h00);
    #3 rst = 1'b0;
    #1;
    model_reset();
    check_all("rst_mid");
    chk("rst_mid_q", {24'h0, q}, 32'h00);
    @(negedge clk) rst = 1'b1;
    step("rs_after", 0, 1, MODE_SHL, 0, 1, 8'h00);
    chk("rs_after_q", {24'h0, q}, 32'h01);

    // Randomized operation mix
    for (int i = 0; i < 300; i++) begin
      step("rand", ($urandom_range(15) == 0), ($urandom_range(3) != 0),
           3'($urandom_range(7)), 1'($urandom_range(1)), 1'($urandom_range(1)),
           8'($urandom_range(255)));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/univ_shift_reg.md
Name: univ_shift_reg

Overview:
- Parametrised universal register, WIDTH bits, successor to the single-bit D flip-flop with reset and set.
- Per-clock modes: hold, logical shift left and right, arithmetic shift right, rotate left and right, parallel load, Johnson (twisted-ring) count.
- A saturating shift counter flags when a full word has been shifted; this lets the block act as serializer, deserializer, ring counter or Johnson counter.
- Used as the generic storage/shift primitive in serial links and sequencers.

Parameters:
- WIDTH, 8, register width in bits; legal range is WIDTH >= 2.
- RST_VAL, {WIDTH{1'b0}}, value loaded into q by rst.
- SET_VAL, {WIDTH{1'b1}}, value loaded into q by set.

Ports:
- clk  input  1  clock; rising edge active.
- rst  input  1  asynchronous, active-low reset.
- set  input  1  synchronous, active-high set; loads SET_VAL.
- en  input  1  clock enable for mode operations.
- mode  input  3  operation select; see Behaviour.
- sin_msb  input  1  serial input entering the MSB on logical right shift.
- sin_lsb  input  1  serial input entering the LSB on left shift.
- d  input  WIDTH  parallel load data.
- q  output  WIDTH  register contents.
- sout_msb  output  1  equals q[WIDTH-1]; combinational from q.
- sout_lsb  output  1  equals q[0]; combinational from q.
- shcnt  output  $clog2(WIDTH+1)  shift operations since the last load, set or reset; saturates at WIDTH.
- word_done  output  1  registered; high while shcnt == WIDTH.

Behaviour:
- Priority, highest first: rst (asynchronous) > set > en=0 (hold) > mode.
- rst low, asynchronous and immediate: q=RST_VAL, shcnt=0, word_done=0. Holds while low.
- Release of rst is synchronous in effect: the first operating edge is the first rising clk with rst high.
- set=1 at a clock edge: q=SET_VAL, shcnt=0, word_done=0. Applies regardless of en and mode.
- en=0, no set: q, shcnt and word_done hold.
- en=1, mode encoding; q+ is the value after the edge, 1-cycle latency for all modes:
  - 000 HOLD: q unchanged; shcnt unchanged.
  - 001 SHR: q+ = {sin_msb, q[W-1:1]}.
  - 010 SHL: q+ = {q[W-2:0], sin_lsb}.
  - 011 LOAD: q+ = d; shcnt+ = 0.
  - 100 ROR: q+ = {q[0], q[W-1:1]}.
  - 101 ROL: q+ = {q[W-2:0], q[W-1]}.
  - 110 JOHN: q+ = {q[W-2:0], ~q[W-1]}.
  - 111 ASR: q+ = {q[W-1], q[W-1:1]}.
- shcnt rules:
  - Modes 001, 010, 100, 101, 110 and 111 each increment shcnt by 1 when shcnt < WIDTH.
  - At WIDTH, shcnt stays at WIDTH (no wrap).
  - word_done+ = (shcnt+ == WIDTH); it rises in the same cycle shcnt reaches WIDTH.
  - shcnt is cleared only by LOAD, set or rst.
- Boundary behaviour:
  - LOAD in the cycle after word_done clears both shcnt and word_done at that edge.
  - set with en=1 and mode=LOAD: set wins; q=SET_VAL.
  - rst asserted mid-shift: q=RST_VAL immediately; the interrupted operation is lost.
- Johnson mode from all-zero walks 2*WIDTH distinct states, then repeats.
- All outputs are defined (no X) after reset.

Decomposition:
- Package univ_shift_reg_pkg holds the mode localparams: MODE_HOLD, MODE_SHR, MODE_SHL, MODE_LOAD, MODE_ROR, MODE_ROL, MODE_JOHN, MODE_ASR, as 3-bit constants.
- The package also holds a function computing shcnt width: $clog2(WIDTH+1).
- One natural sub-module: usr_next_mux. It is purely combinational; from q, d, mode, sin_msb and sin_lsb it computes q_next and is_shift.
- The top holds the q, shcnt and word_done flops, with reset and set priority.

Test Plan (WIDTH=8, RST_VAL=00, SET_VAL=FF):
- Reset and set: rst low mid-cycle gives q=00 immediately with no clk edge; release, then set=1 for one edge gives q=FF, shcnt=0. Set with en=0 still gives q=FF.
- Serializer: LOAD d=A5, then SHL×8 with sin_lsb=0. Required:
  - sout_msb sequence 1,0,1,0,0,1,0,1.
  - q=00 after the 8th shift.
  - shcnt=8 and word_done=1 exactly after the 8th shift edge.
  - A 9th shift keeps shcnt=8.
- Rotate and arithmetic shift:
  - LOAD 81, ROL gives 03, then ROR gives 81.
  - LOAD 90, ASR gives C8, ASR again gives E4.
  - SHR with sin_msb=1 from 00 gives 80.
- Johnson: from reset 00, JOHN×16 gives the sequence 01,03,07,0F,1F,3F,7F,FF,FE,FC,F8,F0,E0,C0,80,00.
- Enable and priority:
  - en=0 with mode=SHL for 3 cycles: q and shcnt unchanged.
  - set=1 with mode=LOAD, d=3C: q=FF.
  - rst low during a SHL sequence: q=00 and shcnt=0 immediately; the first edge after release follows the mode.
